// File: rtl/vga_pkg.sv
// Timing constants for the 640x480@60 VGA raster and the shared coordinate width.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int COORD_W  = 10;

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-TOTAL counter for one raster axis. Reset parks it on the last count
// so the first enabled edge lands on 0. wrap flags an enabled edge at TOTAL-1.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL = H_TOTAL
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               en,
    output logic [COORD_W-1:0] cnt,
    output logic               wrap
);

    localparam logic [COORD_W-1:0] LAST = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);

    assign wrap = en && (cnt == LAST);

    // Count up on enable, wrapping from TOTAL-1 straight to 0.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt <= LAST;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + ONE;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: horizontal/vertical counters plus syncs, active-video
// flag and line/frame strobes. Every decoded output is registered from the
// counters' next values so it lines up with x/y in the same cycle.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE_P  = H_ACTIVE,
    parameter int H_FP_P      = H_FP,
    parameter int H_SYNC_P    = H_SYNC,
    parameter int H_BP_P      = H_BP,
    parameter int V_ACTIVE_P  = V_ACTIVE,
    parameter int V_FP_P      = V_FP,
    parameter int V_SYNC_P    = V_SYNC,
    parameter int V_BP_P      = V_BP,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               pix_ce,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               line_start,
    output logic               frame_start
);

    localparam int HT = H_ACTIVE_P + H_FP_P + H_SYNC_P + H_BP_P;
    localparam int VT = V_ACTIVE_P + V_FP_P + V_SYNC_P + V_BP_P;

    generate
        if (HT > 1024 || VT > 1024) begin : g_total_too_big
            $error("vga_timing_gen: raster total exceeds 10-bit counter range");
        end
    endgenerate

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(HT - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(VT - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE_P);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE_P);
    localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE_P + H_FP_P);
    localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE_P + H_FP_P + H_SYNC_P - 1);
    localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE_P + V_FP_P);
    localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE_P + V_FP_P + V_SYNC_P - 1);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);

    logic [COORD_W-1:0] h;
    logic [COORD_W-1:0] v;
    logic               h_wrap;
    logic               v_wrap;
    logic               v_en;
    logic [COORD_W-1:0] h_next;
    logic [COORD_W-1:0] v_next;

    assign v_en = pix_ce & h_wrap;

    vga_axis_counter #(.TOTAL(HT)) u_h_cnt (
        .clk_in (clk_in),
        .rst    (rst),
        .en     (pix_ce),
        .cnt    (h),
        .wrap   (h_wrap)
    );

    vga_axis_counter #(.TOTAL(VT)) u_v_cnt (
        .clk_in (clk_in),
        .rst    (rst),
        .en     (v_en),
        .cnt    (v),
        .wrap   (v_wrap)
    );

    // Mirror the counters' next values so the decode below tracks them exactly.
    always_comb begin
        h_next = h;
        v_next = v;
        if (rst) begin
            h_next = H_LAST;
            v_next = V_LAST;
        end else begin
            if (pix_ce) begin
                h_next = h_wrap ? '0 : h + ONE;
            end
            if (v_en) begin
                v_next = v_wrap ? '0 : v + ONE;
            end
        end
    end

    // Registered decode of syncs, active area and the one-cycle strobes.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            hsync       <= !SYNC_ACTIVE;
            vsync       <= !SYNC_ACTIVE;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= (h_next >= HS_FIRST && h_next <= HS_LAST) ? SYNC_ACTIVE : !SYNC_ACTIVE;
            vsync       <= (v_next >= VS_FIRST && v_next <= VS_LAST) ? SYNC_ACTIVE : !SYNC_ACTIVE;
            video_on    <= (h_next < H_VIS) && (v_next < V_VIS);
            line_start  <= pix_ce && (h_next == '0);
            frame_start <= pix_ce && (h_next == '0) && (v_next == '0);
        end
    end

    assign x = h;
    assign y = v;

endmodule
